// File: rtl/inst_mem_loader_if.sv
// Handshake and byte-write bus between a host that streams 32-bit
// instruction words and the instruction-memory loader.
// master: host side (drives words and start); slave: loader side.
`timescale 1ns/1ps
interface inst_mem_loader_if;
  logic        start;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_last;
  logic        word_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  word_count;
  logic [31:0] checksum;

  modport master (
    output start, word_in, word_valid, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata, busy, done, word_count, checksum
  );

  modport slave (
    input  start, word_in, word_valid, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata, busy, done, word_count, checksum
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: accepts 32-bit words over valid/ready and
// writes them little-endian into a byte-wide memory port, one byte per
// cycle (4 write cycles per word, 1 word per 5 cycles peak).
// Optional feature macro: INST_MEM_LOADER_CSUM_EN enables a running XOR
// checksum of every fully written word; when undefined checksum reads 0.
// All outputs are registered; reset_n is asynchronous, active low.
`timescale 1ns/1ps
module inst_mem_loader #(
  parameter int MEM_BYTES = 16,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = MEM_BYTES / 4
) (
  input logic              clk,
  input logic              reset_n,
  inst_mem_loader_if.slave bus
);

  localparam int AW = $clog2(MEM_BYTES);
  // The memory only decodes MEM_BYTES bytes, so the byte address is formed
  // modulo MEM_BYTES: a non-zero base wraps back to the bottom of the array.
  localparam logic [AW-1:0] BASE_LOW = BASE_ADDR[AW-1:0];
  localparam logic [AW-1:0] OFF_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] OFF_ZERO = {AW{1'b0}};
  localparam logic [7:0]    MAX_W8   = MAX_WORDS[7:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] offset_q, offset_d;      // offset of the next byte to issue
  logic [1:0]    byte_idx_q, byte_idx_d;  // byte currently on the write port
  logic [31:0]   word_q, word_d;
  logic          last_q, last_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    count_inc_s;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          session_clr_s;           // start accepted: new session
  logic          word_done_s;             // last byte of a word written

  // Little-endian byte lane select: lane 0 is bits 7:0.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign count_inc_s = count_q + 8'd1;

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d       = state_q;
    offset_d      = offset_q;
    byte_idx_d    = byte_idx_q;
    word_d        = word_q;
    last_d        = last_q;
    count_d       = count_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    session_clr_s = 1'b0;
    word_done_s   = 1'b0;
    we_d          = 1'b0;
    ready_d       = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          session_clr_s = 1'b1;
          state_d       = S_ACCEPT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCEPT: begin
        if (bus.word_valid) begin
          word_d     = bus.word_in;
          last_d     = bus.word_last;
          byte_idx_d = 2'd0;
          addr_d     = BASE_LOW + offset_q;
          wdata_d    = bus.word_in[7:0];
          offset_d   = offset_q + OFF_ONE;
          state_d    = S_WRITE;
        end else begin
          state_d = S_ACCEPT;
        end
      end
      S_WRITE: begin
        if (byte_idx_q != 2'd3) begin
          byte_idx_d = byte_idx_q + 2'd1;
          addr_d     = BASE_LOW + offset_q;
          wdata_d    = byte_sel(word_q, byte_idx_d);
          offset_d   = offset_q + OFF_ONE;
          state_d    = S_WRITE;
        end else begin
          word_done_s = 1'b1;
          if (last_q || (count_inc_s == MAX_W8)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACCEPT;
          end
        end
      end
      S_DONE: begin
        if (bus.start) begin
          session_clr_s = 1'b1;
          state_d       = S_ACCEPT;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (session_clr_s) begin
      offset_d = OFF_ZERO;
      count_d  = 8'd0;
    end else if (word_done_s) begin
      count_d = count_inc_s;
    end else begin
      count_d = count_q;
    end

    // Status flags are registered copies of the upcoming state.
    we_d    = (state_d == S_WRITE);
    ready_d = (state_d == S_ACCEPT);
    busy_d  = (state_d == S_ACCEPT) || (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      offset_q   <= OFF_ZERO;
      byte_idx_q <= 2'd0;
      word_q     <= 32'h0;
      last_q     <= 1'b0;
      count_q    <= 8'd0;
      addr_q     <= OFF_ZERO;
      wdata_q    <= 8'h00;
      we_q       <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      offset_q   <= offset_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      last_q     <= last_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef INST_MEM_LOADER_CSUM_EN
  logic [31:0] csum_q;

  // Running XOR of completed words; updates with word_count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= 32'h0;
    end else if (session_clr_s) begin
      csum_q <= 32'h0;
    end else if (word_done_s) begin
      csum_q <= csum_q ^ word_q;
    end else begin
      csum_q <= csum_q;
    end
  end

  assign bus.checksum = csum_q;
`else
  assign bus.checksum = 32'h0;
`endif

  assign bus.word_ready = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = {{(64-AW){1'b0}}, addr_q};
  assign bus.mem_wdata  = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.word_count = count_q;

endmodule
